rob_commit: RTL and testbench

Reorder buffer for the Tomasulo core: the writer side of the register file's commit port. It allocates rename tags to decoded instructions and collects results from the three CDB producers (ALU, LSB, Branch). It retires entries strictly in program order, driving `write_en/addr/tag/data` into the register file. It also raises a one-cycle `clear_o` when a mispredicted branch reaches the head.

---
 rtl/rob_commit_pkg.sv | 20 ++
 rtl/rob_commit.sv | 120 ++++++++++++
 tb/tb_rob_commit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared bus widths, constants and the reorder-buffer entry layout.
package rob_commit_pkg;
   localparam int DataBus = 32;
   localparam int NameBus = 5;
   localparam int RobBus = 4;
   localparam int TagBus = RobBus + 1;
   localparam int Null = 0;
   localparam logic Enable = 1'b1;
   localparam logic Disable = 1'b0;
   localparam logic Valid = 1'b1;
   localparam logic Invalid = 1'b0;
   typedef struct packed {
      logic busy;
      logic ready;
      logic [NameBus-1:0] rd;
      logic [DataBus-1:0] data;
      logic jump;
      logic [DataBus-1:0] pc;
   } rob_entry_t;
endpackage

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that allocates rename tags, collects CDB results
// and retires entries in program order into the register file commit port.
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int DEPTH = 1 << RobBus,
   parameter int TAG_W = TagBus
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               clear,
   input  logic               alloc_en_i,
   input  logic [NameBus-1:0] alloc_rd_i,
   output logic [TAG_W-1:0]   alloc_tag_o,
   output logic               full_o,
   input  logic               cdb1_en_i,
   input  logic [TAG_W-1:0]   cdb1_tag_i,
   input  logic [DataBus-1:0] cdb1_data_i,
   input  logic               cdb2_en_i,
   input  logic [TAG_W-1:0]   cdb2_tag_i,
   input  logic [DataBus-1:0] cdb2_data_i,
   input  logic               cdb3_en_i,
   input  logic [TAG_W-1:0]   cdb3_tag_i,
   input  logic [DataBus-1:0] cdb3_data_i,
   input  logic               cdb3_jump_i,
   input  logic [DataBus-1:0] cdb3_pc_i,
   output logic               write_en_o,
   output logic [NameBus-1:0] write_addr_o,
   output logic [TAG_W-1:0]   write_tag_o,
   output logic [DataBus-1:0] write_data_o,
   output logic               clear_o,
   output logic [DataBus-1:0] pc_o
);
   localparam int IW = $clog2(DEPTH);
   rob_entry_t r_rob [DEPTH];
   logic [IW-1:0] r_head, r_tail;
   logic [IW:0] r_count;
   logic r_write_en, r_clear;
   logic [NameBus-1:0] r_write_addr;
   logic [TAG_W-1:0] r_write_tag;
   logic [DataBus-1:0] r_write_data, r_pc;
   logic w_full, w_alloc, w_commit;
   logic [DEPTH-1:0] w_busy, w_hit1, w_hit2, w_hit3;
   // One-hot decode of tag-1; tags outside 1..DEPTH select nothing.
   function automatic logic [DEPTH-1:0] dec(input logic en, input logic [TAG_W-1:0] tag);
      dec = '0;
      if (en && tag != TAG_W'(Null) && int'(tag) <= DEPTH) dec[IW'(tag - TAG_W'(1))] = 1'b1;
   endfunction
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) w_busy[i] = r_rob[i].busy;
      w_hit1 = dec(cdb1_en_i, cdb1_tag_i) & w_busy;
      w_hit2 = dec(cdb2_en_i, cdb2_tag_i) & w_busy;
      w_hit3 = dec(cdb3_en_i, cdb3_tag_i) & w_busy;
   end
   assign w_full = r_count == (IW+1)'(DEPTH);
   assign w_alloc = rdy && alloc_en_i && !w_full;
   assign w_commit = rdy && r_rob[r_head].busy && r_rob[r_head].ready;
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_head <= '0;
         r_tail <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_rob[i].busy <= Invalid;
         r_write_en <= Disable;
         r_clear <= Disable;
         r_write_addr <= '0;
         r_write_tag <= '0;
         r_write_data <= '0;
         r_pc <= '0;
      end else if (!rdy) begin
         r_write_en <= Disable;
         r_clear <= Disable;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_hit1[i]) begin
               r_rob[i].ready <= Valid;
               r_rob[i].data <= cdb1_data_i;
            end
            if (w_hit2[i]) begin
               r_rob[i].ready <= Valid;
               r_rob[i].data <= cdb2_data_i;
            end
            if (w_hit3[i]) begin
               r_rob[i].ready <= Valid;
               r_rob[i].data <= cdb3_data_i;
               r_rob[i].jump <= cdb3_jump_i;
               r_rob[i].pc <= cdb3_pc_i;
            end
         end
         if (w_alloc) begin
            r_rob[r_tail].busy <= Valid;
            r_rob[r_tail].ready <= Invalid;
            r_rob[r_tail].rd <= alloc_rd_i;
            r_rob[r_tail].jump <= Disable;
            r_tail <= r_tail + IW'(1);
         end
         r_write_en <= w_commit && r_rob[r_head].rd != '0;
         r_clear <= w_commit && r_rob[r_head].jump;
         if (w_commit) begin
            r_rob[r_head].busy <= Invalid;
            r_head <= r_head + IW'(1);
            r_write_addr <= r_rob[r_head].rd;
            r_write_tag <= TAG_W'(r_head) + TAG_W'(1);
            r_write_data <= r_rob[r_head].data;
            if (r_rob[r_head].jump) r_pc <= r_rob[r_head].pc;
         end
         r_count <= r_count + (IW+1)'(w_alloc) - (IW+1)'(w_commit);
      end
   end
   assign alloc_tag_o = TAG_W'(r_tail) + TAG_W'(1);
   assign full_o = w_full;
   assign write_en_o = r_write_en;
   assign write_addr_o = r_write_addr;
   assign write_tag_o = r_write_tag;
   assign write_data_o = r_write_data;
   assign clear_o = r_clear;
   assign pc_o = r_pc;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed stimulus with a commit scoreboard checked by an
// independent monitor on every write/clear pulse.
module tb_rob_commit;
   logic clk = 0, rst = 0, rdy = 1, clear = 0;
   logic alloc_en_i = 0;
   logic [4:0] alloc_rd_i = 0;
   logic [4:0] alloc_tag_o;
   logic full_o;
   logic cdb1_en_i = 0, cdb2_en_i = 0, cdb3_en_i = 0, cdb3_jump_i = 0;
   logic [4:0] cdb1_tag_i = 0, cdb2_tag_i = 0, cdb3_tag_i = 0;
   logic [31:0] cdb1_data_i = 0, cdb2_data_i = 0, cdb3_data_i = 0, cdb3_pc_i = 0;
   logic write_en_o, clear_o;
   logic [4:0] write_addr_o, write_tag_o;
   logic [31:0] write_data_o, pc_o;
   typedef struct {
      logic clr;
      logic [4:0] addr;
      logic [4:0] tag;
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;
   exp_t exp_q[$];
   int checks = 0, errors = 0;
   rob_commit dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .alloc_en_i(alloc_en_i), .alloc_rd_i(alloc_rd_i),
      .alloc_tag_o(alloc_tag_o), .full_o(full_o),
      .cdb1_en_i(cdb1_en_i), .cdb1_tag_i(cdb1_tag_i), .cdb1_data_i(cdb1_data_i),
      .cdb2_en_i(cdb2_en_i), .cdb2_tag_i(cdb2_tag_i), .cdb2_data_i(cdb2_data_i),
      .cdb3_en_i(cdb3_en_i), .cdb3_tag_i(cdb3_tag_i), .cdb3_data_i(cdb3_data_i),
      .cdb3_jump_i(cdb3_jump_i), .cdb3_pc_i(cdb3_pc_i),
      .write_en_o(write_en_o), .write_addr_o(write_addr_o),
      .write_tag_o(write_tag_o), .write_data_o(write_data_o),
      .clear_o(clear_o), .pc_o(pc_o)
   );
   always #5 clk = ~clk;
   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endfunction
   // Monitor: every commit or clear pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (write_en_o || clear_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: tag %0d addr %0d clear %0b with empty scoreboard", write_tag_o, write_addr_o, clear_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_write_en", 32'(write_en_o), 32'(e.addr != 0));
            check("mon_addr", 32'(write_addr_o), 32'(e.addr));
            check("mon_tag", 32'(write_tag_o), 32'(e.tag));
            check("mon_data", write_data_o, e.data);
            check("mon_clear", 32'(clear_o), 32'(e.clr));
            if (e.clr) check("mon_pc", pc_o, e.pc);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end expected end");
      $fatal(1, "timeout");
   end
   task automatic step();
      @(negedge clk);
      rst = 0; clear = 0; alloc_en_i = 0;
      cdb1_en_i = 0; cdb2_en_i = 0; cdb3_en_i = 0; cdb3_jump_i = 0;
   endtask
   task automatic do_reset();
      rst = 1;
      step();
      step();
   endtask
   task automatic alloc(input logic [4:0] rd);
      alloc_en_i = 1; alloc_rd_i = rd;
      step();
   endtask
   task automatic push(input logic clr, input logic [4:0] addr, input logic [4:0] tag,
                       input logic [31:0] data, input logic [31:0] pc);
      exp_t e;
      e.clr = clr; e.addr = addr; e.tag = tag; e.data = data; e.pc = pc;
      exp_q.push_back(e);
   endtask
   initial begin
      // Reset, then a single operation with latency check
      do_reset();
      check("rst_write_en", 32'(write_en_o), 0);
      check("rst_addr", 32'(write_addr_o), 0);
      check("rst_tag", 32'(write_tag_o), 0);
      check("rst_data", write_data_o, 0);
      check("rst_clear", 32'(clear_o), 0);
      check("rst_pc", pc_o, 0);
      check("rst_full", 32'(full_o), 0);
      check("rst_alloc_tag", 32'(alloc_tag_o), 1);
      alloc(5);
      check("t1_alloc_tag", 32'(alloc_tag_o), 2);
      push(0, 5, 1, 32'hDEAD, 0);
      cdb1_en_i = 1; cdb1_tag_i = 1; cdb1_data_i = 32'hDEAD;
      step();
      check("t1_no_early_commit", 32'(write_en_o), 0);
      step();
      check("t1_write_en", 32'(write_en_o), 1);
      step();
      check("t1_pulse_single", 32'(write_en_o), 0);
      // Out-of-order completion, in-order retirement
      do_reset();
      alloc(1); alloc(2); alloc(3);
      push(0, 1, 1, 32'h11, 0);
      push(0, 2, 2, 32'h22, 0);
      push(0, 3, 3, 32'h33, 0);
      cdb1_en_i = 1; cdb1_tag_i = 3; cdb1_data_i = 32'h33;
      step();
      cdb2_en_i = 1; cdb2_tag_i = 1; cdb2_data_i = 32'h11;
      step();
      check("t2_tail_not_committed", 32'(write_en_o), 0);
      cdb1_en_i = 1; cdb1_tag_i = 2; cdb1_data_i = 32'h22;
      step();
      check("t2_commit1_tag", 32'(write_tag_o), 1);
      step();
      check("t2_commit2_tag", 32'(write_tag_o), 2);
      step();
      check("t2_commit3_tag", 32'(write_tag_o), 3);
      step();
      // Full and wrap
      do_reset();
      for (int i = 0; i < 16; i++) alloc(5'(i + 1));
      check("t3_full", 32'(full_o), 1);
      check("t3_full_tag_wrap", 32'(alloc_tag_o), 1);
      alloc(20);
      check("t3_ignored_full", 32'(full_o), 1);
      check("t3_ignored_tag", 32'(alloc_tag_o), 1);
      push(0, 1, 1, 32'h100, 0);
      cdb1_en_i = 1; cdb1_tag_i = 1; cdb1_data_i = 32'h100;
      step();
      alloc(9);
      check("t3_commit_no_admit_full", 32'(full_o), 0);
      check("t3_commit_no_admit_tag", 32'(alloc_tag_o), 1);
      check("t3_commit_en", 32'(write_en_o), 1);
      alloc(9);
      check("t3_refill_full", 32'(full_o), 1);
      check("t3_refill_tag", 32'(alloc_tag_o), 2);
      // rd = 0 consumes the entry without a register write
      do_reset();
      alloc(0);
      cdb2_en_i = 1; cdb2_tag_i = 1; cdb2_data_i = 32'h55;
      step();
      step();
      check("t4_rd0_no_write", 32'(write_en_o), 0);
      check("t4_rd0_tag", 32'(write_tag_o), 1);
      check("t4_rd0_data", write_data_o, 32'h55);
      push(0, 7, 2, 32'h77, 0);
      alloc(7);
      cdb1_en_i = 1; cdb1_tag_i = 2; cdb1_data_i = 32'h77;
      step();
      step();
      check("t4_next_commit", 32'(write_en_o), 1);
      // Mispredicted branch at the head
      do_reset();
      alloc(1); alloc(2); alloc(3); alloc(4);
      push(1, 1, 1, 32'h44, 32'h1000);
      cdb3_en_i = 1; cdb3_tag_i = 1; cdb3_data_i = 32'h44; cdb3_jump_i = 1; cdb3_pc_i = 32'h1000;
      step();
      step();
      check("t5_clear", 32'(clear_o), 1);
      check("t5_pc", pc_o, 32'h1000);
      clear = 1;
      alloc_en_i = 1; alloc_rd_i = 6;
      cdb1_en_i = 1; cdb1_tag_i = 2; cdb1_data_i = 32'h99;
      step();
      check("t5_clear_single", 32'(clear_o), 0);
      check("t5_flush_write_en", 32'(write_en_o), 0);
      check("t5_flush_tag", 32'(alloc_tag_o), 1);
      check("t5_flush_full", 32'(full_o), 0);
      step();
      check("t5_flush_no_commit", 32'(write_en_o), 0);
      // Stall holds a ready head
      do_reset();
      alloc(3);
      push(0, 3, 1, 32'hAB, 0);
      cdb1_en_i = 1; cdb1_tag_i = 1; cdb1_data_i = 32'hAB;
      step();
      for (int i = 0; i < 3; i++) begin
         rdy = 0; alloc_en_i = 1; alloc_rd_i = 4;
         step();
         check("t6_stall_no_commit", 32'(write_en_o), 0);
      end
      check("t6_stall_no_alloc", 32'(alloc_tag_o), 2);
      rdy = 1;
      step();
      check("t6_resume_commit", 32'(write_en_o), 1);
      check("t6_resume_tag", 32'(write_tag_o), 1);
      step();
      step();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
